lsu_mem_stage: RTL and testbench
================================

Name: lsu_mem_stage

Overview:
- Memory-access stage directly downstream of the ALU→LSU pipeline register. Consumes lsu_reg_wdata/lsu_rd_reg_en/lsu_rd_reg_addr/lsu_pc/lsu_inst.
- Decodes loads and stores, runs a req/gnt/rvalid data-memory handshake and aligns load data. Non-memory instructions pass through.
- Registers the result into the LSU→WB pipeline outputs (wb_*). Asserts lsu_stall so the upstream register holds while an access is in flight.

Parameters:
- BUS_TIMEOUT, 16, cycles spent in REQ+WAIT_R before the access is aborted (≥2).

Ports:
- clk  in  1  clock
- rst_n  in  1  async active-low reset
- lsu_reg_wdata  in  32  ALU result; effective address for loads/stores
- lsu_rd_reg_en  in  1  rd write enable
- lsu_rd_reg_addr  in  5  rd index
- lsu_pc  in  32  instruction PC
- lsu_inst  in  32  instruction word
- lsu_rs2_data  in  32  store data
- lsu_stall  out  1  hold upstream register (combinational)
- lsu_bus_err  out  1  one-cycle timeout pulse (registered)
- dmem_req  out  1  bus request
- dmem_we  out  1  1=store
- dmem_addr  out  32  word-aligned address
- dmem_be  out  4  byte enables
- dmem_wdata  out  32  lane-replicated store data
- dmem_gnt  in  1  request accepted
- dmem_rvalid  in  1  load data valid
- dmem_rdata  in  32  load data
- wb_valid, wb_reg_wdata[32], wb_rd_reg_en, wb_rd_reg_addr[5], wb_pc[32], wb_inst[32]  out  registered WB-stage outputs

Behaviour:
- Reset (async, rst_n=0): all wb_* = 0, lsu_bus_err = 0, state = IDLE, timeout counter = 0. dmem_req = 0 immediately.
- Decode:
  - is_load: opcode 7'b0000011.
  - is_store: opcode 7'b0100011.
  - is_mem = is_load | is_store.
  - Size and extension from funct3: 0 B, 1 H, 2 W, 4 BU, 5 HU. Any other funct3 is a word access.
- FSM states: IDLE, REQ, WAIT_R.
  - IDLE & is_mem → REQ.
  - REQ & dmem_gnt: store → IDLE (done); load → WAIT_R.
  - WAIT_R & dmem_rvalid → IDLE (done).
  - REQ/WAIT_R & counter == BUS_TIMEOUT-1 & not done → IDLE (abort).
- dmem_req = (state == REQ). dmem_we = is_store. All bus outputs are driven from the held lsu_* inputs.
- Completion and stall:
  - done = (REQ & is_store & dmem_gnt) | (WAIT_R & dmem_rvalid).
  - lsu_stall = is_mem & !done & !abort.
  - The upstream register holds while lsu_stall is high. The instruction is therefore never captured internally.
- Timeout counter: cleared in IDLE, increments each cycle in REQ/WAIT_R.
- Latency (gnt in the REQ cycle, rvalid in the next cycle):
  - Load: 3 cycles, wb_* valid after cycle 3.
  - Store: 2 cycles.
  - Non-memory instruction: 1 cycle, no stall.
- wb update every edge:
  - Non-mem: wb_valid=1. Copy rd_en, rd_addr, pc, inst; wb_reg_wdata = lsu_reg_wdata.
  - Load done: wb_reg_wdata = extracted, extended data; rd_en/rd_addr copied.
  - Store done: wb_valid=1, wb_rd_reg_en=0.
  - Stall cycle or abort: bubble (wb_valid=0, wb_rd_reg_en=0, other wb_* = 0).
- Alignment:
  - dmem_addr = {addr[31:2], 2'b00}.
  - dmem_be: B = 1<<addr[1:0]; H = 4'b0011<<{addr[1],1'b0}; W = 4'b1111.
  - dmem_wdata: B replicates the byte ×4; H replicates the half ×2.
  - Load data is selected by addr[1:0] (H uses addr[1]). Sign-extended for B/H, zero-extended for BU/HU.
- Abort: lsu_bus_err = 1 for exactly one cycle. Bubble to WB. lsu_stall drops, so upstream advances and the instruction is dropped.
- Misaligned without the feature below: low address bits beyond the access size are ignored (force-aligned).
- A late gnt/rvalid arriving in IDLE is ignored.

Optional Feature:
- Macro: LSU_MISALIGN_CHK_EN.
- Defined:
  - H with addr[0]=1, or W with addr[1:0]≠0, stays in IDLE and never asserts dmem_req.
  - lsu_stall = 0 for that instruction.
  - Registered output lsu_misalign (1 bit, reset 0) pulses for one cycle; WB receives a bubble.
- Undefined: the lsu_misalign port is absent; force-align behaviour applies.

Decomposition:
- Package lsu_pkg:
  - Opcode constants OPC_LOAD, OPC_STORE.
  - funct3 constants F3_B/H/W/BU/HU.
  - State encoding ST_IDLE/ST_REQ/ST_WAIT_R (2 bits).
- Sub-module lsu_align (combinational): dmem_be, dmem_wdata and load extraction/extension from funct3, addr[1:0], rs2 and rdata.
- The FSM, timeout counter and WB register stay in lsu_mem_stage.

Test Plan:
- ADDI x5 (inst 0x00500293, wdata 5) → next cycle wb_valid=1, wb_reg_wdata=5, wb_rd_reg_addr=5; lsu_stall never high.
- LB x6, addr 0x103; gnt in REQ cycle, rdata 0x80FF_0000 next cycle → be 4'b1000, dmem_addr 0x100, wb_reg_wdata 0xFFFF_FF80 after 3 cycles; stall high for 2 cycles.
- SH rs2 0x1234_ABCD, addr 0x202, gnt after 3 wait cycles → dmem_wdata 0xABCD_ABCD, be 4'b1100, dmem_we=1; wb_valid=1 with wb_rd_reg_en=0 at completion.
- LW with dmem_gnt tied 0, BUS_TIMEOUT=16 → dmem_req high 16 cycles, then lsu_bus_err pulse, bubble, state IDLE.
- rst_n dropped while in WAIT_R → dmem_req=0 and all wb_*=0 immediately; after release a new LHU at 0x2 with rdata 0xBEEF_0000 returns 0x0000_BEEF.
- With LSU_MISALIGN_CHK_EN: LW at 0x5 → lsu_misalign pulse, no dmem_req, bubble to WB.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared decode constants, FSM encoding and WB-register layout for the LSU memory stage.
package lsu_pkg;

  localparam logic [6:0] OPC_LOAD  = 7'b0000011;
  localparam logic [6:0] OPC_STORE = 7'b0100011;

  localparam logic [2:0] F3_B  = 3'd0;
  localparam logic [2:0] F3_H  = 3'd1;
  localparam logic [2:0] F3_W  = 3'd2;
  localparam logic [2:0] F3_BU = 3'd4;
  localparam logic [2:0] F3_HU = 3'd5;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_REQ    = 2'd1,
    ST_WAIT_R = 2'd2
  } lsu_state_e;

  typedef enum logic [1:0] {
    SZ_B,
    SZ_H,
    SZ_W
  } access_size_e;

  typedef struct packed {
    logic        valid;
    logic [31:0] reg_wdata;
    logic        rd_en;
    logic [4:0]  rd_addr;
    logic [31:0] pc;
    logic [31:0] inst;
  } wb_t;

  // Unlisted funct3 encodings fall back to a full-word access.
  function automatic access_size_e access_size(input logic [2:0] funct3);
    case (funct3)
      F3_B, F3_BU: return SZ_B;
      F3_H, F3_HU: return SZ_H;
      F3_W:        return SZ_W;
      default:     return SZ_W;
    endcase
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering for the LSU: store byte enables / lane replication and
// load-data extraction with sign or zero extension.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] rs2_data,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  output logic [31:0] load_data
);

  access_size_e size;
  logic         unsigned_ext;
  logic [7:0]   byte_sel;
  logic [15:0]  half_sel;

  assign size         = access_size(funct3);
  assign unsigned_ext = funct3[2];
  assign byte_sel     = rdata[{addr_lo, 3'b000} +: 8];
  assign half_sel     = addr_lo[1] ? rdata[31:16] : rdata[15:0];

  always_comb begin
    be        = 4'b1111;
    wdata     = rs2_data;
    load_data = rdata;
    unique case (size)
      SZ_B: begin
        be        = 4'b0001 << addr_lo;
        wdata     = {4{rs2_data[7:0]}};
        load_data = unsigned_ext ? {24'b0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
      end
      SZ_H: begin
        be        = addr_lo[1] ? 4'b1100 : 4'b0011;
        wdata     = {2{rs2_data[15:0]}};
        load_data = unsigned_ext ? {16'b0, half_sel} : {{16{half_sel[15]}}, half_sel};
      end
      default: begin
        be        = 4'b1111;
        wdata     = rs2_data;
        load_data = rdata;
      end
    endcase
  end

endmodule

// File: rtl/lsu_mem_stage.sv
// LSU memory-access stage: req/gnt/rvalid data-bus FSM with timeout abort and LSU->WB register.
// Define LSU_MISALIGN_CHK_EN to trap misaligned H/W accesses instead of force-aligning them.
module lsu_mem_stage
  import lsu_pkg::*;
#(
  parameter int unsigned BUS_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] lsu_reg_wdata,
  input  logic        lsu_rd_reg_en,
  input  logic [4:0]  lsu_rd_reg_addr,
  input  logic [31:0] lsu_pc,
  input  logic [31:0] lsu_inst,
  input  logic [31:0] lsu_rs2_data,
  output logic        lsu_stall,
  output logic        lsu_bus_err,
`ifdef LSU_MISALIGN_CHK_EN
  output logic        lsu_misalign,
`endif
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_gnt,
  input  logic        dmem_rvalid,
  input  logic [31:0] dmem_rdata,
  output logic        wb_valid,
  output logic [31:0] wb_reg_wdata,
  output logic        wb_rd_reg_en,
  output logic [4:0]  wb_rd_reg_addr,
  output logic [31:0] wb_pc,
  output logic [31:0] wb_inst
);

  localparam int unsigned    CW      = (BUS_TIMEOUT > 2) ? $clog2(BUS_TIMEOUT) : 1;
  localparam logic [CW-1:0]  CNT_MAX = CW'(BUS_TIMEOUT - 1);

  lsu_state_e    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  wb_t           wb_q, wb_d;
  logic          bus_err_q;
  logic [6:0]    opcode;
  logic [2:0]    funct3;
  logic          is_load, is_store, is_mem;
  logic          done, abort, misalign;
  logic [31:0]   load_data;

  assign opcode   = lsu_inst[6:0];
  assign funct3   = lsu_inst[14:12];
  assign is_load  = (opcode == OPC_LOAD);
  assign is_store = (opcode == OPC_STORE);
  assign is_mem   = is_load | is_store;

`ifdef LSU_MISALIGN_CHK_EN
  logic misalign_q;
  assign misalign = is_mem && (state_q == ST_IDLE) &&
                    (((access_size(funct3) == SZ_H) && lsu_reg_wdata[0]) ||
                     ((access_size(funct3) == SZ_W) && (lsu_reg_wdata[1:0] != 2'b00)));
  assign lsu_misalign = misalign_q;
`else
  assign misalign = 1'b0;
`endif

  lsu_align u_align (
    .funct3    (funct3),
    .addr_lo   (lsu_reg_wdata[1:0]),
    .rs2_data  (lsu_rs2_data),
    .rdata     (dmem_rdata),
    .be        (dmem_be),
    .wdata     (dmem_wdata),
    .load_data (load_data)
  );

  assign dmem_req  = (state_q == ST_REQ);
  assign dmem_we   = is_store;
  assign dmem_addr = {lsu_reg_wdata[31:2], 2'b00};
  assign lsu_stall = is_mem & ~done & ~abort & ~misalign;

  // The timeout check overrides any non-completing transition, including a load gnt on the last cycle.
  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    done    = 1'b0;
    abort   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (is_mem && !misalign) state_d = ST_REQ;
      end
      ST_REQ: begin
        cnt_d = cnt_q + CW'(1);
        if (dmem_gnt) begin
          if (is_store) begin
            done    = 1'b1;
            state_d = ST_IDLE;
          end else begin
            state_d = ST_WAIT_R;
          end
        end
      end
      ST_WAIT_R: begin
        cnt_d = cnt_q + CW'(1);
        if (dmem_rvalid) begin
          done    = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if ((state_q != ST_IDLE) && (cnt_q == CNT_MAX) && !done) begin
      abort   = 1'b1;
      state_d = ST_IDLE;
    end
    if (state_d == ST_IDLE) cnt_d = '0;
  end

  // Anything that is neither a pass-through nor a completed access becomes a bubble.
  always_comb begin
    wb_d = '0;
    if (!is_mem) begin
      wb_d.valid     = 1'b1;
      wb_d.reg_wdata = lsu_reg_wdata;
      wb_d.rd_en     = lsu_rd_reg_en;
      wb_d.rd_addr   = lsu_rd_reg_addr;
      wb_d.pc        = lsu_pc;
      wb_d.inst      = lsu_inst;
    end else if (done) begin
      wb_d.valid = 1'b1;
      wb_d.pc    = lsu_pc;
      wb_d.inst  = lsu_inst;
      if (is_load) begin
        wb_d.reg_wdata = load_data;
        wb_d.rd_en     = lsu_rd_reg_en;
        wb_d.rd_addr   = lsu_rd_reg_addr;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      wb_q      <= '0;
      bus_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      wb_q      <= wb_d;
      bus_err_q <= abort;
    end
  end

`ifdef LSU_MISALIGN_CHK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) misalign_q <= 1'b0;
    else        misalign_q <= misalign;
  end
`endif

  assign lsu_bus_err    = bus_err_q;
  assign wb_valid       = wb_q.valid;
  assign wb_reg_wdata   = wb_q.reg_wdata;
  assign wb_rd_reg_en   = wb_q.rd_en;
  assign wb_rd_reg_addr = wb_q.rd_addr;
  assign wb_pc          = wb_q.pc;
  assign wb_inst        = wb_q.inst;

endmodule

// File: tb/tb_lsu_mem_stage.sv
// Self-checking bench for lsu_mem_stage; plays the data memory and compares against a lane-arithmetic model.
module tb_lsu_mem_stage;

  localparam int         BUS_TIMEOUT = 16;
  localparam logic [6:0] OPC_LD      = 7'b0000011;
  localparam logic [6:0] OPC_ST      = 7'b0100011;
  localparam logic [31:0] NOP_INST   = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] lsu_reg_wdata = '0;
  logic        lsu_rd_reg_en = 1'b0;
  logic [4:0]  lsu_rd_reg_addr = '0;
  logic [31:0] lsu_pc = '0;
  logic [31:0] lsu_inst = NOP_INST;
  logic [31:0] lsu_rs2_data = '0;
  logic        lsu_stall, lsu_bus_err;
  logic        dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata;
  logic [3:0]  dmem_be;
  logic        dmem_gnt = 1'b0;
  logic        dmem_rvalid = 1'b0;
  logic [31:0] dmem_rdata = '0;
  logic        wb_valid, wb_rd_reg_en;
  logic [31:0] wb_reg_wdata, wb_pc, wb_inst;
  logic [4:0]  wb_rd_reg_addr;
`ifdef LSU_MISALIGN_CHK_EN
  logic        lsu_misalign;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  lsu_mem_stage #(.BUS_TIMEOUT(BUS_TIMEOUT)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .lsu_reg_wdata   (lsu_reg_wdata),
    .lsu_rd_reg_en   (lsu_rd_reg_en),
    .lsu_rd_reg_addr (lsu_rd_reg_addr),
    .lsu_pc          (lsu_pc),
    .lsu_inst        (lsu_inst),
    .lsu_rs2_data    (lsu_rs2_data),
    .lsu_stall       (lsu_stall),
    .lsu_bus_err     (lsu_bus_err),
`ifdef LSU_MISALIGN_CHK_EN
    .lsu_misalign    (lsu_misalign),
`endif
    .dmem_req        (dmem_req),
    .dmem_we         (dmem_we),
    .dmem_addr       (dmem_addr),
    .dmem_be         (dmem_be),
    .dmem_wdata      (dmem_wdata),
    .dmem_gnt        (dmem_gnt),
    .dmem_rvalid     (dmem_rvalid),
    .dmem_rdata      (dmem_rdata),
    .wb_valid        (wb_valid),
    .wb_reg_wdata    (wb_reg_wdata),
    .wb_rd_reg_en    (wb_rd_reg_en),
    .wb_rd_reg_addr  (wb_rd_reg_addr),
    .wb_pc           (wb_pc),
    .wb_inst         (wb_inst)
  );

  // Number of bytes touched by an access with this funct3.
  function automatic int model_bytes(input logic [2:0] f3);
    if (f3 == 3'd0 || f3 == 3'd4) return 1;
    if (f3 == 3'd1 || f3 == 3'd5) return 2;
    return 4;
  endfunction

  function automatic logic [3:0] model_be(input logic [2:0] f3, input logic [31:0] addr);
    int n, first;
    logic [3:0] be;
    n     = model_bytes(f3);
    first = (int'(addr[1:0]) / n) * n;
    be    = '0;
    for (int b = 0; b < 4; b++) if (b >= first && b < first + n) be[b] = 1'b1;
    return be;
  endfunction

  function automatic logic [31:0] model_wdata(input logic [2:0] f3, input logic [31:0] rs2);
    int n;
    n = model_bytes(f3);
    if (n == 1) return {24'b0, rs2[7:0]} * 32'h0101_0101;
    if (n == 2) return {16'b0, rs2[15:0]} * 32'h0001_0001;
    return rs2;
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] addr,
                                             input logic [31:0] rdata);
    int n, first;
    longint v, lim;
    n     = model_bytes(f3);
    if (n == 4) return rdata;
    first = (int'(addr[1:0]) / n) * n;
    lim   = longint'(1) << (8 * n);
    v     = longint'((rdata >> (8 * first))) % lim;
    if (!f3[2] && v >= lim / 2) v = v - lim;
    return 32'(v);
  endfunction

  task automatic set_inputs(input logic [31:0] inst, input logic [31:0] wd, input logic en,
                            input logic [4:0] rd, input logic [31:0] pc, input logic [31:0] rs2);
    lsu_inst = inst; lsu_reg_wdata = wd; lsu_rd_reg_en = en;
    lsu_rd_reg_addr = rd; lsu_pc = pc; lsu_rs2_data = rs2;
  endtask

  task automatic set_nop();
    set_inputs(NOP_INST, 32'h0, 1'b0, 5'd0, 32'h0, 32'h0);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    set_inputs({17'h0, 3'd2, 5'd3, OPC_LD}, 32'h40, 1'b1, 5'd3, 32'h100, 32'h0);
    dmem_gnt = 1'b1; dmem_rvalid = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if (dmem_req !== 1'b0) begin errors++; $display("[TB] FAIL reset_req: got %b expected 0", dmem_req); end
    checks++;
    if (lsu_bus_err !== 1'b0) begin errors++; $display("[TB] FAIL reset_bus_err: got %b expected 0", lsu_bus_err); end
    checks++;
    if ({wb_valid, wb_reg_wdata, wb_rd_reg_en, wb_rd_reg_addr, wb_pc, wb_inst} !== '0)
      begin errors++; $display("[TB] FAIL reset_wb: got %h expected 0",
                               {wb_valid, wb_reg_wdata, wb_rd_reg_en, wb_rd_reg_addr, wb_pc, wb_inst}); end
    @(negedge clk);
    dmem_gnt = 1'b0; dmem_rvalid = 1'b0; set_nop();
    rst_n = 1'b1;
  endtask

  // Stray gnt/rvalid in IDLE are driven on purpose; they must be ignored.
  task automatic test_passthrough();
    for (int i = 0; i < 8; i++) begin
      logic [31:0] inst, wd, pc;
      logic        en;
      logic [4:0]  rd;
      inst = $urandom; wd = $urandom; pc = $urandom; en = 1'($urandom); rd = 5'($urandom);
      if (inst[6:0] == OPC_LD || inst[6:0] == OPC_ST) inst[2] = ~inst[2];
      if (i == 0) begin inst = 32'h0050_0293; wd = 32'd5; en = 1'b1; rd = 5'd5; end
      @(negedge clk);
      set_inputs(inst, wd, en, rd, pc, $urandom);
      dmem_gnt = 1'($urandom); dmem_rvalid = 1'($urandom);
      #1;
      checks++;
      if ({lsu_stall, dmem_req} !== 2'b00)
        begin errors++; $display("[TB] FAIL pass_stall_req: got %b expected 00", {lsu_stall, dmem_req}); end
      @(posedge clk); #1;
      checks++;
      if ({wb_valid, wb_reg_wdata, wb_rd_reg_en, wb_rd_reg_addr, wb_pc, wb_inst} !== {1'b1, wd, en, rd, pc, inst})
        begin errors++; $display("[TB] FAIL pass_wb: got %h expected %h",
          {wb_valid, wb_reg_wdata, wb_rd_reg_en, wb_rd_reg_addr, wb_pc, wb_inst}, {1'b1, wd, en, rd, pc, inst}); end
    end
    @(negedge clk);
    dmem_gnt = 1'b0; dmem_rvalid = 1'b0; set_nop();
  endtask

  task automatic test_load();
    for (int i = 0; i < 8; i++) begin
      logic [31:0] inst, addr, rdata, pc, exp;
      logic [2:0]  f3;
      logic [4:0]  rd;
      logic        en;
      int          gw, rw;
      f3 = 3'($urandom); addr = $urandom; rdata = $urandom; pc = $urandom;
      rd = 5'($urandom); en = 1'($urandom); gw = $urandom_range(0, 3); rw = $urandom_range(0, 3);
      if (i == 0) begin f3 = 3'd0; addr = 32'h103; rdata = 32'h80FF_0000; rd = 5'd6; en = 1'b1; gw = 0; rw = 0; end
`ifdef LSU_MISALIGN_CHK_EN
      if (model_bytes(f3) == 2) addr[0] = 1'b0;
      if (model_bytes(f3) == 4) addr[1:0] = 2'b00;
`endif
      inst = $urandom; inst[6:0] = OPC_LD; inst[14:12] = f3; inst[11:7] = rd;
      exp  = model_load(f3, addr, rdata);
      if (i == 0) exp = 32'hFFFF_FF80;
      @(negedge clk);
      set_inputs(inst, addr, en, rd, pc, $urandom);
      #1;
      checks++;
      if ({lsu_stall, dmem_req} !== 2'b10)
        begin errors++; $display("[TB] FAIL load_idle: got %b expected 10", {lsu_stall, dmem_req}); end
      @(negedge clk); #1;
      checks++;
      if ({dmem_req, dmem_we, dmem_addr, dmem_be} !== {1'b1, 1'b0, addr & 32'hFFFF_FFFC, model_be(f3, addr)})
        begin errors++; $display("[TB] FAIL load_req: got %h expected %h", {dmem_req, dmem_we, dmem_addr, dmem_be},
                                 {1'b1, 1'b0, addr & 32'hFFFF_FFFC, model_be(f3, addr)}); end
      for (int k = 0; k < gw; k++) begin @(negedge clk); #1; end
      dmem_gnt = 1'b1;
      #1;
      checks++;
      if ({lsu_stall, dmem_req} !== 2'b11)
        begin errors++; $display("[TB] FAIL load_gnt: got %b expected 11", {lsu_stall, dmem_req}); end
      @(negedge clk);
      dmem_gnt = 1'b0;
      for (int k = 0; k < rw; k++) begin @(negedge clk); end
      #1;
      checks++;
      if ({lsu_stall, dmem_req} !== 2'b10)
        begin errors++; $display("[TB] FAIL load_wait_r: got %b expected 10", {lsu_stall, dmem_req}); end
      dmem_rvalid = 1'b1; dmem_rdata = rdata;
      #1;
      checks++;
      if (lsu_stall !== 1'b0) begin errors++; $display("[TB] FAIL load_done_stall: got %b expected 0", lsu_stall); end
      @(posedge clk); #1;
      checks++;
      if ({wb_valid, wb_reg_wdata, wb_rd_reg_en, wb_rd_reg_addr, wb_pc, wb_inst} !== {1'b1, exp, en, rd, pc, inst})
        begin errors++; $display("[TB] FAIL load_wb: got %h expected %h",
          {wb_valid, wb_reg_wdata, wb_rd_reg_en, wb_rd_reg_addr, wb_pc, wb_inst}, {1'b1, exp, en, rd, pc, inst}); end
      @(negedge clk);
      dmem_rvalid = 1'b0; dmem_rdata = $urandom; set_nop();
    end
  endtask

  task automatic test_store();
    for (int i = 0; i < 8; i++) begin
      logic [31:0] inst, addr, rs2, exp_wd;
      logic [3:0]  exp_be;
      logic [2:0]  f3;
      int          gw;
      f3 = 3'($urandom); addr = $urandom; rs2 = $urandom; gw = $urandom_range(0, 4);
      if (i == 0) begin f3 = 3'd1; addr = 32'h202; rs2 = 32'h1234_ABCD; gw = 3; end
`ifdef LSU_MISALIGN_CHK_EN
      if (model_bytes(f3) == 2) addr[0] = 1'b0;
      if (model_bytes(f3) == 4) addr[1:0] = 2'b00;
`endif
      inst = $urandom; inst[6:0] = OPC_ST; inst[14:12] = f3;
      exp_wd = model_wdata(f3, rs2);
      exp_be = model_be(f3, addr);
      if (i == 0) begin exp_wd = 32'hABCD_ABCD; exp_be = 4'b1100; end
      @(negedge clk);
      set_inputs(inst, addr, 1'b1, 5'($urandom), $urandom, rs2);
      #1;
      checks++;
      if ({lsu_stall, dmem_req} !== 2'b10)
        begin errors++; $display("[TB] FAIL store_idle: got %b expected 10", {lsu_stall, dmem_req}); end
      for (int k = 0; k <= gw; k++) begin
        @(negedge clk); #1;
        checks++;
        if ({lsu_stall, dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata} !==
            {1'b1, 1'b1, 1'b1, addr & 32'hFFFF_FFFC, exp_be, exp_wd})
          begin errors++; $display("[TB] FAIL store_req: got %h expected %h",
            {lsu_stall, dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata},
            {1'b1, 1'b1, 1'b1, addr & 32'hFFFF_FFFC, exp_be, exp_wd}); end
      end
      dmem_gnt = 1'b1;
      #1;
      checks++;
      if (lsu_stall !== 1'b0) begin errors++; $display("[TB] FAIL store_done_stall: got %b expected 0", lsu_stall); end
      @(posedge clk); #1;
      checks++;
      if ({wb_valid, wb_rd_reg_en} !== 2'b10)
        begin errors++; $display("[TB] FAIL store_wb: got %b expected 10", {wb_valid, wb_rd_reg_en}); end
      @(negedge clk);
      dmem_gnt = 1'b0; set_nop();
    end
  endtask

  task automatic test_timeout();
    int  req_cycles;
    bool_t_dummy: begin end
    req_cycles = 0;
    @(negedge clk);
    set_inputs({17'h0, 3'd2, 5'd7, OPC_LD}, 32'h300, 1'b1, 5'd7, 32'h44, 32'h0);
    for (int k = 0; k < 3 * BUS_TIMEOUT; k++) begin
      @(negedge clk); #1;
      if (dmem_req) req_cycles++;
      if (!lsu_stall || lsu_bus_err) break;
    end
    checks++;
    if (req_cycles !== BUS_TIMEOUT || lsu_stall !== 1'b0 || dmem_req !== 1'b1)
      begin errors++; $display("[TB] FAIL timeout_req_cycles: got %0d req cycles (stall %b) expected %0d",
                               req_cycles, lsu_stall, BUS_TIMEOUT); end
    checks++;
    if (lsu_bus_err !== 1'b0) begin errors++; $display("[TB] FAIL timeout_early_err: got %b expected 0", lsu_bus_err); end
    @(posedge clk); #1;
    checks++;
    if ({lsu_bus_err, wb_valid, wb_rd_reg_en} !== 3'b100)
      begin errors++; $display("[TB] FAIL timeout_abort: got %b expected 100", {lsu_bus_err, wb_valid, wb_rd_reg_en}); end
    @(negedge clk);
    set_nop();
    #1;
    checks++;
    if (dmem_req !== 1'b0) begin errors++; $display("[TB] FAIL timeout_idle: got %b expected 0", dmem_req); end
    @(posedge clk); #1;
    checks++;
    if ({lsu_bus_err, wb_valid} !== 2'b01)
      begin errors++; $display("[TB] FAIL timeout_pulse: got %b expected 01", {lsu_bus_err, wb_valid}); end
  endtask

  task automatic test_reset_wait();
    logic [31:0] inst;
    @(negedge clk);
    set_inputs({17'h0, 3'd2, 5'd9, OPC_LD}, 32'h80, 1'b1, 5'd9, 32'h88, 32'h0);
    @(negedge clk);
    dmem_gnt = 1'b1;
    @(negedge clk);
    dmem_gnt = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({dmem_req, lsu_bus_err} !== 2'b00)
      begin errors++; $display("[TB] FAIL rst_wait_req: got %b expected 00", {dmem_req, lsu_bus_err}); end
    checks++;
    if ({wb_valid, wb_reg_wdata, wb_rd_reg_en, wb_rd_reg_addr, wb_pc, wb_inst} !== '0)
      begin errors++; $display("[TB] FAIL rst_wait_wb: got %h expected 0",
                               {wb_valid, wb_reg_wdata, wb_rd_reg_en, wb_rd_reg_addr, wb_pc, wb_inst}); end
    @(negedge clk);
    rst_n = 1'b1;
    inst = {17'h0, 3'd5, 5'd12, OPC_LD};
    set_inputs(inst, 32'h2, 1'b1, 5'd12, 32'hC0, 32'h0);
    #1;
    checks++;
    if ({lsu_stall, dmem_req} !== 2'b10)
      begin errors++; $display("[TB] FAIL rst_lhu_idle: got %b expected 10", {lsu_stall, dmem_req}); end
    @(negedge clk); #1;
    checks++;
    if (dmem_req !== 1'b1) begin errors++; $display("[TB] FAIL rst_lhu_req: got %b expected 1", dmem_req); end
    dmem_gnt = 1'b1;
    @(negedge clk);
    dmem_gnt = 1'b0; dmem_rvalid = 1'b1; dmem_rdata = 32'hBEEF_0000;
    @(posedge clk); #1;
    checks++;
    if ({wb_valid, wb_reg_wdata, wb_rd_reg_addr} !== {1'b1, 32'h0000_BEEF, 5'd12})
      begin errors++; $display("[TB] FAIL rst_lhu_wb: got %h expected %h",
                               {wb_valid, wb_reg_wdata, wb_rd_reg_addr}, {1'b1, 32'h0000_BEEF, 5'd12}); end
    @(negedge clk);
    dmem_rvalid = 1'b0; set_nop();
  endtask

`ifdef LSU_MISALIGN_CHK_EN
  task automatic test_misalign();
    @(negedge clk);
    set_inputs({17'h0, 3'd2, 5'd4, OPC_LD}, 32'h5, 1'b1, 5'd4, 32'h200, 32'h0);
    #1;
    checks++;
    if ({lsu_stall, dmem_req} !== 2'b00)
      begin errors++; $display("[TB] FAIL mis_lw_stall: got %b expected 00", {lsu_stall, dmem_req}); end
    @(posedge clk); #1;
    checks++;
    if ({lsu_misalign, wb_valid, wb_rd_reg_en} !== 3'b100)
      begin errors++; $display("[TB] FAIL mis_lw_pulse: got %b expected 100", {lsu_misalign, wb_valid, wb_rd_reg_en}); end
    @(negedge clk);
    set_inputs({17'h0, 3'd1, 5'd0, OPC_ST}, 32'h201, 1'b1, 5'd0, 32'h204, 32'h55);
    #1;
    checks++;
    if ({lsu_stall, dmem_req} !== 2'b00)
      begin errors++; $display("[TB] FAIL mis_sh_stall: got %b expected 00", {lsu_stall, dmem_req}); end
    @(negedge clk);
    set_nop();
    #1;
    checks++;
    if ({dmem_req, lsu_misalign, wb_valid} !== 3'b010)
      begin errors++; $display("[TB] FAIL mis_sh_pulse: got %b expected 010", {dmem_req, lsu_misalign, wb_valid}); end
    @(posedge clk); #1;
    checks++;
    if ({lsu_misalign, wb_valid} !== 2'b01)
      begin errors++; $display("[TB] FAIL mis_clear: got %b expected 01", {lsu_misalign, wb_valid}); end
  endtask
`endif

  initial begin
    test_reset();
    test_passthrough();
    test_load();
    test_store();
    test_timeout();
    test_reset_wait();
`ifdef LSU_MISALIGN_CHK_EN
    test_misalign();
`endif
    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
